regfile_dump: RTL and testbench
===============================

# regfile_dump

Debug readback engine for the 16-bit register file. On a start pulse it walks a contiguous, wrapping range of register addresses through the file's read port, one register at a time. Each value is captured into a holding register and streamed out over a valid/ready handshake. It is the read-side counterpart of the register write path and sits between the register file's read port and the debug/trace interface.

## Interface
Parameters:
- DATA_W, 16, register data width
- NUM_REGS, 8, number of registers in the file (2..2^ADDR_W)
- ADDR_W, 3, register address width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle request to begin a dump; sampled only in IDLE
- first_reg  in  ADDR_W  first register address of the dump; sampled with start
- count  in  ADDR_W+1  number of registers to dump; sampled with start
- rd_addr  out  ADDR_W  address driven to the register-file read port
- rd_data  in  DATA_W  combinational read data for rd_addr
- out_valid  out  1  out_data/out_addr/out_last hold a beat
- out_ready  in  1  consumer accepts the beat when high together with out_valid
- out_data  out  DATA_W  captured register value
- out_addr  out  ADDR_W  address the value came from
- out_last  out  1  final beat of the dump
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the dump completes

## Operation
- FSM states are IDLE, READ, SEND and FIN.
- IDLE, start=1:
  - latch cur_addr=first_reg.
  - latch remaining=min(count, NUM_REGS).
  - if the clamped count is 0, go to FIN; otherwise go to READ.
- IDLE, start=0: stay in IDLE.
- READ:
  - rd_addr=cur_addr.
  - at the clock edge, out_data<=rd_data, out_addr<=cur_addr, out_last<=(remaining==1).
  - go to SEND.
- SEND:
  - out_valid=1.
  - out_data, out_addr and out_last stay stable until the handshake (out_valid && out_ready).
  - on handshake with remaining==1, go to FIN.
  - on handshake with remaining>1:
    - cur_addr<=(cur_addr==NUM_REGS-1) ? 0 : cur_addr+1.
    - remaining<=remaining-1.
    - go to READ.
  - with no handshake, stay in SEND.
- FIN: done=1 for exactly this one cycle, then go to IDLE.
- rd_addr outside READ: holds cur_addr, so the value is don't-care for the file but deterministic.
- start outside IDLE: ignored; it does not restart or extend the dump.
- Snapshot semantics: each value is the register contents at its READ edge. Writes to a register after its capture edge do not change the beat already held.
- Address wrap is modulo NUM_REGS, not modulo 2^ADDR_W. first_reg >= NUM_REGS is out of range; the first increment wraps it to 0, and the first beat's content is undefined.
- out_ready may be high in any state. It has effect only in SEND.

## Timing
- Reset (asynchronous, any state, including mid-dump): state=IDLE, out_valid=0, out_data=0, out_addr=0, out_last=0, busy=0, done=0, rd_addr=0, cur_addr=0, remaining=0. Any in-flight beat is dropped and no done pulse is produced.
- Start accepted at edge k:
  - cycle k+1: READ (busy=1).
  - edge k+2: first value captured; first beat has out_valid=1 from cycle k+2.
- Throughput: at most one beat per 2 cycles (READ+SEND) with out_ready held high.
- N-register dump with out_ready always high: beats valid at cycles k+2, k+4, …, k+2N. FIN (done=1) at cycle k+2N+1. busy falls at cycle k+2N+2.
- count=0: FIN at cycle k+1 and no beats.
- Back-to-back dumps: start is re-sampled in IDLE the cycle after FIN. The minimum gap from done to the next start acceptance is 1 cycle.
- Backpressure: each cycle with out_ready=0 in SEND adds one cycle. out_valid never drops before the handshake.

## Test plan
- Reset values: assert rst mid-SEND with out_ready=0 → all outputs 0 within the same cycle; after release, no done pulse and IDLE behaviour holds.
- Basic dump: preload R0..R7=16'h1000+i; start, first_reg=2, count=3, out_ready=1 → beats (addr,data) = (2,1002),(3,1003),(4,1004); out_last only on the third beat; done one cycle after the last handshake; exact cycle offsets k+2/k+4/k+6/k+7.
- Wrap and clamp: first_reg=6, count=10 → 8 beats with addresses 6,7,0,1,2,3,4,5; out_last on address 5.
- Backpressure: toggle out_ready randomly → beats stay stable while stalled, none lost or duplicated; a write to R3 after its capture edge does not alter the held out_data.
- Edge cases:
  - count=0 → done at k+1 with no out_valid.
  - start pulsed during busy → ignored, sequence unchanged.
  - start in the cycle after done → new dump accepted.

Source files
------------

// File: rtl/regfile_dump.sv
// Debug readback engine: walks a wrapping range of register-file addresses,
// captures each value and streams it out over a valid/ready handshake.
module regfile_dump #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   first_reg,
    input  logic [ADDR_W:0]     count,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [DATA_W-1:0]   rd_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [ADDR_W-1:0]   out_addr,
    output logic                out_last,
    output logic                busy,
    output logic                done
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  NUM_REGS_C  = CNT_W'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST_ADDR_C = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [ADDR_W-1:0]   cur_addr_r, cur_addr_nxt_s;
    logic [CNT_W-1:0]    remaining_r, remaining_nxt_s;
    logic [CNT_W-1:0]    clamp_s;
    logic                capture_s;

    logic                out_valid_r;
    logic [DATA_W-1:0]   out_data_r;
    logic [ADDR_W-1:0]   out_addr_r;
    logic                out_last_r;
    logic                busy_r;
    logic                done_r;

    // Clamp the requested count to the size of the file.
    always_comb begin
        if (count > NUM_REGS_C) begin
            clamp_s = NUM_REGS_C;
        end else begin
            clamp_s = count;
        end
    end

    // Next-state, address walk and capture strobe.
    always_comb begin
        state_nxt_s     = state_r;
        cur_addr_nxt_s  = cur_addr_r;
        remaining_nxt_s = remaining_r;
        capture_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    cur_addr_nxt_s  = first_reg;
                    remaining_nxt_s = clamp_s;
                    if (clamp_s == {CNT_W{1'b0}}) begin
                        state_nxt_s = FIN;
                    end else begin
                        state_nxt_s = READ;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            READ: begin
                capture_s   = 1'b1;
                state_nxt_s = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    if (remaining_r == CNT_W'(1)) begin
                        state_nxt_s = FIN;
                    end else begin
                        // Out-of-range start addresses also fold back to 0 here.
                        if (cur_addr_r >= LAST_ADDR_C) begin
                            cur_addr_nxt_s = {ADDR_W{1'b0}};
                        end else begin
                            cur_addr_nxt_s = cur_addr_r + ADDR_W'(1);
                        end
                        remaining_nxt_s = remaining_r - CNT_W'(1);
                        state_nxt_s     = READ;
                    end
                end else begin
                    state_nxt_s = SEND;
                end
            end
            FIN: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Control state and registered status outputs, decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cur_addr_r  <= {ADDR_W{1'b0}};
            remaining_r <= {CNT_W{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cur_addr_r  <= cur_addr_nxt_s;
            remaining_r <= remaining_nxt_s;
            out_valid_r <= (state_nxt_s == SEND);
            busy_r      <= (state_nxt_s != IDLE);
            done_r      <= (state_nxt_s == FIN);
        end
    end

    // Beat holding register: loaded only on the READ edge, so it is a snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_r <= {DATA_W{1'b0}};
            out_addr_r <= {ADDR_W{1'b0}};
            out_last_r <= 1'b0;
        end else if (capture_s) begin
            out_data_r <= rd_data;
            out_addr_r <= cur_addr_r;
            out_last_r <= (remaining_r == CNT_W'(1));
        end
    end

    assign rd_addr   = cur_addr_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_addr  = out_addr_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: a behavioural register-file model plus
// per-dump expected beat lists derived from the address walk rules.
module tb_regfile_dump;

    localparam int DW = 16;
    localparam int NR = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] first_reg;
    logic [AW:0]   count;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] regs [NR];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign rd_data = regs[rd_addr];

    regfile_dump #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .first_reg(first_reg), .count(count),
        .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr), .out_last(out_last),
        .busy(busy), .done(done)
    );

    // Run one dump. Start is presented in the current cycle; the task returns
    // positioned in the cycle after done, so a following call starts back-to-back.
    task automatic run_dump(input int first, input int cnt, input bit rand_ready,
                            input bit exact_timing, input bit mid_start, input bit poke3);
        logic [AW-1:0] exp_addr [$];
        logic [DW-1:0] exp_data [$];
        int n, b, t, last_hs;
        bit fin, poked, rdy, exp_v, exp_last;
        n = (cnt > NR) ? NR : cnt;
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(AW'((first + i) % NR));
            exp_data.push_back(regs[(first + i) % NR]);
        end
        start     = 1'b1;
        first_reg = AW'(first);
        count     = (AW+1)'(cnt);
        @(posedge clk); #1;
        start = 1'b0;
        b = 0; t = 1; last_hs = 0; fin = 1'b0; poked = 1'b0;
        while (!fin && t < 200) begin
            if (mid_start && t == 3) begin
                start = 1'b1; first_reg = AW'(first + 4); count = (AW+1)'(1);
            end else begin
                start = 1'b0;
            end
            rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (poke3 && out_valid && out_addr == AW'(3) && !poked) begin
                regs[3] = 16'hbeef;
                rdy = 1'b0;
                poked = 1'b1;
            end
            out_ready = rdy;
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_during_dump t=%0d got=%b want=1", t, busy);
            end
            if (exact_timing) begin
                exp_v = (t >= 2) && (t <= 2*n) && (t % 2 == 0);
                checks++;
                if (out_valid !== exp_v || done !== (t == 2*n + 1)) begin
                    errors++;
                    $display("FAIL cycle_timing t=%0d got valid=%b done=%b want valid=%b done=%b",
                             t, out_valid, done, exp_v, (t == 2*n + 1));
                end
            end
            if (out_valid) begin
                checks++;
                if (b >= n) begin
                    errors++;
                    $display("FAIL extra_beat t=%0d got addr=%0d beats=%0d want beats=%0d",
                             t, out_addr, b + 1, n);
                end else begin
                    exp_last = (b == n - 1);
                    if ({out_addr, out_data, out_last, rd_addr} !==
                        {exp_addr[b], exp_data[b], exp_last, exp_addr[b]}) begin
                        errors++;
                        $display("FAIL beat%0d got addr=%0d data=%h last=%b rd_addr=%0d want addr=%0d data=%h last=%b",
                                 b, out_addr, out_data, out_last, rd_addr,
                                 exp_addr[b], exp_data[b], exp_last);
                    end
                    if (rdy) begin
                        b++;
                        last_hs = t;
                    end
                end
            end
            if (done) begin
                checks++;
                if (b != n || t != last_hs + 1) begin
                    errors++;
                    $display("FAIL done_position t=%0d beats=%0d want t=%0d beats=%0d",
                             t, b, last_hs + 1, n);
                end
                fin = 1'b1;
            end
            @(posedge clk); #1;
            t++;
        end
        start = 1'b0;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL dump_timeout got no done want done within 200 cycles");
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_done got busy=%b done=%b valid=%b want 0 0 0", busy, done, out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; first_reg = '0; count = '0; out_ready = 1'b0;
        for (int i = 0; i < NR; i++) regs[i] = DW'(16'h1000 + i);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_data, out_addr, out_last, busy, done, rd_addr} !== '0) begin
            errors++;
            $display("FAIL reset_initial got valid=%b data=%h addr=%0d last=%b busy=%b done=%b rd=%0d want all 0",
                     out_valid, out_data, out_addr, out_last, busy, done, rd_addr);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; first_reg = AW'(5); count = (AW+1)'(4);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 10 && !out_valid; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_setup got valid=%b want 1", out_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_data, out_addr, out_last, busy, done, rd_addr} !== '0) begin
            errors++;
            $display("FAIL reset_mid_send got valid=%b data=%h addr=%0d last=%b busy=%b done=%b rd=%0d want all 0",
                     out_valid, out_data, out_addr, out_last, busy, done, rd_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got done=%b busy=%b valid=%b want 0 0 0",
                         i, done, busy, out_valid);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < NR; i++) regs[i] = DW'(16'h1000 + i);
        run_dump(2, 3, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_wrap_clamp();
        run_dump(6, 10, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_count_zero();
        run_dump(5, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_busy_start();
        run_dump(1, 3, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_dump(0, 2, 1'b0, 1'b1, 1'b0, 1'b0);
        run_dump(4, 2, 1'b0, 1'b1, 1'b0, 1'b0);
        run_dump(7, 1, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < NR; i++) regs[i] = DW'($urandom);
        run_dump(0, 8, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < NR; i++) regs[i] = DW'($urandom);
            run_dump(int'($urandom_range(0, NR - 1)), int'($urandom_range(0, 15)),
                     1'b1, 1'b0, 1'b0, 1'b0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap_clamp();
        test_count_zero();
        test_busy_start();
        test_back_to_back();
        test_backpressure();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
